// File: rtl/controller_reader_m.sv
// Serial reader for NES-style game controllers. A rising edge on start_fetch
// (GPU frame start) runs one latch pulse followed by eight bit periods on a
// shared shift clock; each controller's data line is sampled once per bit and
// the assembled bytes are published to `buttons` atomically with fetch_done.
module controller_reader_m #(
  parameter int NUM_CONTROLLERS = 2,
  parameter int HALF_PERIOD     = 76
) (
  input  logic                         clk_12_5875,
  input  logic                         rst,
  input  logic                         start_fetch,
  input  logic [NUM_CONTROLLERS-1:0]   controller_data_in,
  output logic                         controller_latch,
  output logic                         controller_clk,
  output logic [8*NUM_CONTROLLERS-1:0] buttons,
  output logic                         busy,
  output logic                         fetch_done
);

  localparam int PW = $clog2(HALF_PERIOD * 2);
  localparam logic [PW-1:0] LATCH_LAST = PW'(2 * HALF_PERIOD - 1);
  localparam logic [PW-1:0] HALF_LAST  = PW'(HALF_PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    LOW,
    HIGH,
    DONE
  } state_t;

  state_t                              state;
  logic [PW-1:0]                       phase;
  logic [2:0]                          bit_cnt;
  logic [NUM_CONTROLLERS-1:0]          data_sync_p0;
  logic [NUM_CONTROLLERS-1:0]          data_sync_p1;
  logic                                start_prev;
  logic                                start_rise;
  logic [NUM_CONTROLLERS-1:0][7:0]     shreg;
  logic [NUM_CONTROLLERS-1:0][7:0]     shift_next;

  // Two-flop synchroniser for the asynchronous controller pads.
  always_ff @(posedge clk_12_5875 or posedge rst) begin
    if (rst) begin
      data_sync_p0 <= '0;
      data_sync_p1 <= '0;
    end else begin
      data_sync_p0 <= controller_data_in;
      data_sync_p1 <= data_sync_p0;
    end
  end

  // Registered rising-edge detect; history resets high so a level already
  // present at reset release is not mistaken for a new frame start.
  always_ff @(posedge clk_12_5875 or posedge rst) begin
    if (rst) begin
      start_prev <= 1'b1;
      start_rise <= 1'b0;
    end else begin
      start_prev <= start_fetch;
      start_rise <= start_fetch & ~start_prev;
    end
  end

  // Next shift-register contents: pad data is active-low, stored active-high,
  // MSB first so the first bit received ends up in bit 7.
  always_comb begin
    shift_next = shreg;
    for (int n = 0; n < NUM_CONTROLLERS; n++) begin
      shift_next[n] = {shreg[n][6:0], ~data_sync_p1[n]};
    end
  end

  // Fetch sequencer with registered outputs.
  always_ff @(posedge clk_12_5875 or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      phase            <= '0;
      bit_cnt          <= '0;
      shreg            <= '0;
      buttons          <= '0;
      controller_latch <= 1'b0;
      controller_clk   <= 1'b0;
      busy             <= 1'b0;
      fetch_done       <= 1'b0;
    end else begin
      fetch_done <= 1'b0;
      case (state)
        IDLE: begin
          phase   <= '0;
          bit_cnt <= '0;
          if (start_rise) begin
            state            <= LATCH;
            controller_latch <= 1'b1;
            busy             <= 1'b1;
          end
        end
        LATCH: begin
          if (phase == LATCH_LAST) begin
            phase            <= '0;
            bit_cnt          <= '0;
            controller_latch <= 1'b0;
            state            <= LOW;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        LOW: begin
          if (phase == HALF_LAST) begin
            phase <= '0;
            shreg <= shift_next;
            if (bit_cnt == 3'd7) begin
              buttons    <= shift_next;
              fetch_done <= 1'b1;
              state      <= DONE;
            end else begin
              controller_clk <= 1'b1;
              state          <= HIGH;
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end
        HIGH: begin
          if (phase == HALF_LAST) begin
            phase          <= '0;
            bit_cnt        <= bit_cnt + 3'd1;
            controller_clk <= 1'b0;
            state          <= LOW;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        DONE: begin
          phase <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          phase            <= '0;
          controller_latch <= 1'b0;
          controller_clk   <= 1'b0;
          busy             <= 1'b0;
          state            <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controller_reader_m.sv
// Bench for controller_reader_m: a default two-controller instance and a
// fast single-controller instance, checked every cycle against a timeline
// model derived from the fetch timing rules.
module tb_controller_reader_m;

  logic        clk = 1'b0;
  logic        rst;
  logic        sf_a, sf_b;
  logic [1:0]  pad_a;
  logic [0:0]  pad_b;
  logic        latch_a, cclk_a, busy_a, done_a;
  logic [15:0] btn_a;
  logic        latch_b, cclk_b, busy_b, done_b;
  logic [7:0]  btn_b;

  always #5 clk = ~clk;

  controller_reader_m dut_a (
    .clk_12_5875       (clk),
    .rst               (rst),
    .start_fetch       (sf_a),
    .controller_data_in(pad_a),
    .controller_latch  (latch_a),
    .controller_clk    (cclk_a),
    .buttons           (btn_a),
    .busy              (busy_a),
    .fetch_done        (done_a)
  );

  controller_reader_m #(.NUM_CONTROLLERS(1), .HALF_PERIOD(2)) dut_b (
    .clk_12_5875       (clk),
    .rst               (rst),
    .start_fetch       (sf_b),
    .controller_data_in(pad_b),
    .controller_latch  (latch_b),
    .controller_clk    (cclk_b),
    .buttons           (btn_b),
    .busy              (busy_b),
    .fetch_done        (done_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  int          hp[2] = '{76, 2};
  int          nc[2] = '{2, 1};
  bit          act[2];
  int          e[2];
  logic        sfprev[2];
  logic [1:0]  samp[2][8];
  logic [15:0] bexp[2];
  int          cyc = 0;

  // Stimulus for the next clock edge
  logic        nx_rst = 1'b1;
  logic        nx_sf[2];
  logic [1:0]  nx_pad_a = 2'b11;
  logic [0:0]  nx_pad_b = 1'b1;

  // Observation counters
  int   latch_cnt[2], rise_cnt[2], clkhi_cnt[2], done_cnt[2], busy_cnt[2];
  int   done_at[2], latch_first[2], latch_last[2], latch_rise_cyc[2];
  logic clk_prev[2], latch_prev[2];

  task automatic clr_cnt();
    for (int i = 0; i < 2; i++) begin
      latch_cnt[i] = 0; rise_cnt[i] = 0; clkhi_cnt[i] = 0; done_cnt[i] = 0;
      busy_cnt[i] = 0; done_at[i] = -1; latch_first[i] = -1; latch_last[i] = -1;
      latch_rise_cyc[i] = -1;
    end
  endtask

  // Expected {latch, clk, busy, done} for DUT id in absolute cycle n.
  function automatic logic [3:0] expect_ctl(input int id, input int n);
    int   h, c;
    logic l, k, b, d;
    h = hp[id];
    c = n - e[id];
    if (!act[id]) return 4'b0000;
    l = (c >= 1) && (c <= 2 * h);
    k = (c > 3 * h) && (c <= 17 * h) && (((c - 3 * h - 1) % (2 * h)) < h);
    b = (c >= 1) && (c <= 17 * h + 1);
    d = (c == 17 * h + 1);
    return {l, k, b, d};
  endfunction

  function automatic logic stream_bit(input logic [7:0] st, input int cn, input int h);
    int k;
    if (cn <= 3 * h) k = 0;
    else k = (cn - 3 * h + 2 * h - 1) / (2 * h);
    if (k > 7) k = 7;
    return st[k];
  endfunction

  // One cycle: check outputs at the negedge, then drive the next inputs.
  task automatic step();
    logic [3:0]  ce, co;
    logic [15:0] bo;
    logic [1:0]  pv;
    int          h, c, cn;
    @(negedge clk);
    for (int id = 0; id < 2; id++) begin
      h = hp[id];
      c = cyc - e[id];
      if (act[id] && c == 17 * h + 1) begin
        for (int j = 0; j < nc[id]; j++)
          for (int k = 0; k < 8; k++) bexp[id][8 * j + 7 - k] = samp[id][k][j];
      end
      ce = expect_ctl(id, cyc);
      co = (id == 0) ? {latch_a, cclk_a, busy_a, done_a} : {latch_b, cclk_b, busy_b, done_b};
      bo = (id == 0) ? btn_a : {8'h00, btn_b};
      check_eq((id == 0) ? "ctl_a" : "ctl_b", {28'd0, co}, {28'd0, ce});
      check_eq((id == 0) ? "buttons_a" : "buttons_b", {16'd0, bo}, {16'd0, bexp[id]});
      if (co[3]) begin
        latch_cnt[id]++;
        if (latch_first[id] < 0) latch_first[id] = c;
        latch_last[id] = c;
        if (!latch_prev[id]) latch_rise_cyc[id] = cyc;
      end
      if (co[2]) clkhi_cnt[id]++;
      if (co[2] && !clk_prev[id]) rise_cnt[id]++;
      if (co[1]) busy_cnt[id]++;
      if (co[0]) begin done_cnt[id]++; done_at[id] = c; end
      clk_prev[id]   = co[2];
      latch_prev[id] = co[3];
    end
    rst   = nx_rst;
    sf_a  = nx_sf[0];
    sf_b  = nx_sf[1];
    pad_a = nx_pad_a;
    pad_b = nx_pad_b;
    for (int id = 0; id < 2; id++) begin
      h  = hp[id];
      pv = (id == 0) ? nx_pad_a : {1'b0, nx_pad_b};
      if (nx_rst) begin
        act[id] = 1'b0; bexp[id] = '0; sfprev[id] = 1'b1;
      end else begin
        if (nx_sf[id] && !sfprev[id] && (!act[id] || (cyc + 1 - e[id] >= 17 * h + 2))) begin
          act[id] = 1'b1;
          e[id]   = cyc + 1;
        end
        sfprev[id] = nx_sf[id];
        if (act[id]) begin
          cn = cyc + 2 - e[id];
          if (cn >= 3 * h && ((cn - 3 * h) % (2 * h)) == 0 && ((cn - 3 * h) / (2 * h)) <= 7)
            samp[id][(cn - 3 * h) / (2 * h)] = ~pv;
        end
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      nx_sf[0] = 1'b0; nx_sf[1] = 1'b0;
      nx_pad_a = 2'($urandom); nx_pad_b = 1'($urandom);
      step();
    end
  endtask

  // Fetch on the big instance. mode 0: random pads, 1: all pressed,
  // 2: fixed stream on controller 0 plus a second start pulse mid-fetch.
  task automatic fetch_a(input int mode, input int stop_rel);
    logic [7:0] st;
    int rel;
    st = 8'b1011_0110;
    nx_sf[0] = 1'b0; step();
    nx_sf[0] = 1'b1; step();
    while (cyc - e[0] < stop_rel) begin
      rel = cyc - e[0];
      nx_sf[0] = (rel < 9) || (mode == 2 && rel >= 500 && rel < 510);
      case (mode)
        0:       nx_pad_a = 2'($urandom);
        1:       nx_pad_a = 2'b00;
        default: nx_pad_a = {1'b1, stream_bit(st, cyc + 2 - e[0], 76)};
      endcase
      nx_sf[1] = 1'b0; nx_pad_b = 1'($urandom);
      step();
    end
    nx_sf[0] = 1'b0;
  endtask

  // Fetch on the small instance. mode 0: random pads, 3: pad pressed from
  // one cycle before bit 3's sample point onward.
  task automatic fetch_b(input int mode, input int stop_rel);
    int rel;
    nx_sf[1] = 1'b0; step();
    nx_sf[1] = 1'b1; step();
    while (cyc - e[1] < stop_rel) begin
      rel = cyc - e[1];
      nx_sf[1] = (rel < 3);
      if (mode == 3) nx_pad_b = (cyc + 2 - e[1] >= 19) ? 1'b0 : 1'b1;
      else           nx_pad_b = 1'($urandom);
      nx_sf[0] = 1'b0; nx_pad_a = 2'($urandom);
      step();
    end
    nx_sf[1] = 1'b0;
  endtask

  int e_old;

  initial begin
    rst = 1'b1; sf_a = 1'b0; sf_b = 1'b0; pad_a = 2'b11; pad_b = 1'b1;
    for (int i = 0; i < 2; i++) begin
      act[i] = 1'b0; e[i] = 0; sfprev[i] = 1'b1; bexp[i] = '0;
      nx_sf[i] = 1'b0; clk_prev[i] = 1'b0; latch_prev[i] = 1'b0;
    end
    clr_cnt();

    // Reset state
    nx_rst = 1'b1;
    idle(3);
    check_eq("rst_latch", {31'd0, latch_a}, 32'd0);
    check_eq("rst_clk", {31'd0, cclk_a}, 32'd0);
    check_eq("rst_busy", {31'd0, busy_a}, 32'd0);
    check_eq("rst_done", {31'd0, done_a}, 32'd0);
    check_eq("rst_buttons", {16'd0, btn_a}, 32'd0);
    nx_rst = 1'b0;
    idle(5);

    // Directed fetch with a second start pulse mid-fetch
    clr_cnt();
    fetch_a(2, 17 * 76 + 4);
    check_eq("t1_btn0", {24'd0, btn_a[7:0]}, 32'b1001_0010);
    check_eq("t1_btn1", {24'd0, btn_a[15:8]}, 32'h00);
    check_eq("t1_latch_cnt", latch_cnt[0], 152);
    check_eq("t1_latch_first", latch_first[0], 1);
    check_eq("t1_latch_last", latch_last[0], 152);
    check_eq("t1_clk_pulses", rise_cnt[0], 7);
    check_eq("t1_clk_high", clkhi_cnt[0], 7 * 76);
    check_eq("t1_done_cnt", done_cnt[0], 1);
    check_eq("t1_done_at", done_at[0], 1293);
    check_eq("t1_busy_cnt", busy_cnt[0], 1293);
    idle(10);

    // start_fetch already high when reset releases
    nx_rst = 1'b1; nx_sf[0] = 1'b1;
    for (int i = 0; i < 3; i++) step();
    clr_cnt();
    nx_rst = 1'b0;
    for (int i = 0; i < 20; i++) step();
    nx_sf[0] = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check_eq("t3_no_fetch_busy", busy_cnt[0], 0);
    check_eq("t3_no_fetch_latch", latch_cnt[0], 0);
    clr_cnt();
    fetch_a(0, 17 * 76 + 4);
    check_eq("t3_fetch_done_cnt", done_cnt[0], 1);
    idle(5);

    // All pressed, then reset in the middle of the next fetch
    fetch_a(1, 17 * 76 + 4);
    check_eq("t4_all_pressed", {16'd0, btn_a}, 32'hFFFF);
    idle(3);
    fetch_a(0, 700);
    #1;
    rst = 1'b1; nx_rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      act[i] = 1'b0; bexp[i] = '0; sfprev[i] = 1'b1;
    end
    #1;
    check_eq("t4_async_latch", {31'd0, latch_a}, 32'd0);
    check_eq("t4_async_clk", {31'd0, cclk_a}, 32'd0);
    check_eq("t4_async_busy", {31'd0, busy_a}, 32'd0);
    check_eq("t4_async_done", {31'd0, done_a}, 32'd0);
    check_eq("t4_async_buttons", {16'd0, btn_a}, 32'd0);
    for (int i = 0; i < 3; i++) step();
    nx_rst = 1'b0;
    idle(4);
    clr_cnt();
    fetch_a(2, 17 * 76 + 4);
    check_eq("t4_refetch_btn", {16'd0, btn_a}, 32'h0092);
    check_eq("t4_refetch_done", done_cnt[0], 1);
    idle(5);

    // Fast instance: timing, synchroniser latency, back-to-back edges
    clr_cnt();
    fetch_b(3, 35);
    e_old = e[1];
    nx_sf[1] = 1'b1;
    step();
    check_eq("t5_btn", {24'd0, btn_b}, 32'h0F);
    check_eq("t5_latch_cnt", latch_cnt[1], 4);
    check_eq("t5_latch_first", latch_first[1], 1);
    check_eq("t5_done_at", done_at[1], 35);
    check_eq("t5_done_cnt", done_cnt[1], 1);
    for (int i = 0; i < 3; i++) begin
      nx_pad_b = 1'($urandom); step();
    end
    check_eq("t6_b2b_latch_rise", latch_rise_cyc[1], e_old + 37);
    nx_sf[1] = 1'b0;
    while (cyc - e[1] < 40) begin
      nx_pad_b = 1'($urandom); step();
    end
    check_eq("t6_b2b_done_cnt", done_cnt[1], 2);

    // Edge landing in the DONE cycle is dropped
    idle(3);
    clr_cnt();
    fetch_b(0, 34);
    nx_sf[1] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      nx_pad_b = 1'($urandom); step();
    end
    nx_sf[1] = 1'b0;
    idle(40);
    check_eq("t7_done_edge_ignored", done_cnt[1], 1);

    // Randomised start pulses, pads and occasional resets on both instances
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) nx_sf[0] = ~nx_sf[0];
      if ($urandom_range(0, 7) == 0)   nx_sf[1] = ~nx_sf[1];
      nx_pad_a = 2'($urandom);
      nx_pad_b = 1'($urandom);
      nx_rst   = ($urandom_range(0, 1999) == 0);
      step();
    end
    nx_rst = 1'b0;
    idle(1400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/controller_reader_m.md
Name: controller_reader_m

Overview:
- Other end of the GPU's `controller_start_fetch` strobe.
- On each frame-start strobe, the block runs a serial read of NES-style game controllers: it drives a latch pulse and a shared shift clock, then samples one serial data line per controller.
- It assembles 8 button bits per controller and publishes them atomically to the CPU-visible register file, with a one-cycle completion pulse.
- Runs in the pixel clock domain alongside the GPU.

Parameters:
- NUM_CONTROLLERS, 2, number of controllers sharing latch/clock; each has its own data line.
- HALF_PERIOD, 76, pixel-clock cycles per half shift-clock period (~6 us at 12.5875 MHz); legal range 2..1023.

Ports:
- clk_12_5875  input  1  pixel clock; only clock.
- rst  input  1  asynchronous, active-high reset.
- start_fetch  input  1  level from GPU (high for 10 cycles at frame start); the block acts on its rising edge only.
- controller_data_in  input  NUM_CONTROLLERS  raw serial data pads, active-low (0 = pressed), asynchronous.
- controller_latch  output  1  latch/strobe to controllers.
- controller_clk  output  1  shared shift clock; idle low.
- buttons  output  8*NUM_CONTROLLERS  controller n in bits [8n+7:8n], active-high. Bit 7=A, 6=B, 5=Select, 4=Start, 3=Up, 2=Down, 1=Left, 0=Right.
- busy  output  1  high from latch assertion through the fetch_done cycle.
- fetch_done  output  1  single-cycle pulse when `buttons` updates.

Behaviour:
- Reset (async, active-high):
  - State IDLE; controller_latch=0, controller_clk=0, busy=0, fetch_done=0, buttons=0.
  - Phase counter=0, bit counter=0, shift registers=0, synchronisers=0.
  - Edge-detect history register resets to 1, so a start_fetch that is already high at reset release does not trigger a fetch.
- Synchronisation: each controller_data_in bit passes through a 2-flop synchroniser. All samples below use the synchroniser output. Data is inverted on capture.
- Edge detection: edge = start_fetch & ~start_fetch_prev, registered each cycle.
  - The edge is honoured only in IDLE; edges while busy are ignored (not queued).
  - A continuously high start_fetch never retriggers.
- Timing: cycle 0 = the cycle the edge is detected; H = HALF_PERIOD.
- States:
  - IDLE: outputs idle. On edge → LATCH.
  - LATCH:
    - controller_latch=1 and busy=1 for cycles 1..2H.
    - Then → LOW with bit counter=0.
  - LOW:
    - controller_clk=0 for H cycles.
    - On the last cycle, shift the inverted sample into each controller's shift register, MSB first (first received bit ends in bit 7).
    - Bit k is sampled at cycle 3H+2kH.
    - If bit counter=7 → DONE; else → HIGH.
  - HIGH:
    - controller_clk=1 for H cycles, then bit counter++ and → LOW.
    - There are exactly 7 clock pulses; no pulse follows bit 7.
  - DONE (cycle 17H+1):
    - All shift registers copy into buttons simultaneously; fetch_done=1 and busy=1 for this single cycle.
    - Then → IDLE; busy=0 from the next cycle.
- buttons changes only in the DONE cycle or on reset; it is stable at all other times, including mid-fetch.
- Phase counter: width clog2(HALF_PERIOD*2). It counts 0..limit-1 and reloads 0 on each state change; no wrap beyond the limit.
- Reset mid-fetch: the outputs drop immediately (async) and buttons clears to 0. The next fetch requires a fresh rising edge after reset release.
- Start edge in the DONE cycle: ignored (state is not IDLE).
- An edge in the first IDLE cycle after DONE is honoured.

Test Plan:
- Default params, controller 0 pad pattern A/Start/Left pressed (pad stream 0,1,1,0,1,1,0,1), controller 1 all released → after edge:
  - latch high exactly cycles 1..152;
  - 7 clk pulses, each 76 cycles high;
  - fetch_done only at cycle 1293;
  - buttons[7:0]=8'b1001_0010, buttons[15:8]=8'h00.
- start_fetch held high 10 cycles, then a second pulse at cycle 500 (mid-fetch) → exactly one fetch; busy stays 1 to cycle 1293; no second fetch occurs.
- start_fetch high while rst deasserts, held high 20 cycles → no fetch. A following rising edge → a normal fetch.
- Complete fetch loading buttons=16'hFFFF (all pressed), then assert rst at cycle 700 of the next fetch → latch, clk, busy, fetch_done, buttons all 0 asynchronously (same cycle). A new edge → full fetch with correct data.
- HALF_PERIOD=2, single controller:
  - latch cycles 1..4;
  - bit k sampled at cycle 6+4k;
  - fetch_done at cycle 35.
  - Toggle the pad 1 cycle before a sample point → old value captured (2-flop synchroniser latency).
- Back-to-back edges: an edge in the cycle after fetch_done → new fetch starts; latch rises the next cycle.
